// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// No handshake: every signal is a plain per-cycle level, sampled by the datapath on the next clk edge.
interface multicycle_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUControl;
  logic [3:0]  State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: FETCH/DECODE/EXEC/MEM/WB sequencer, condition flags
// and conditional gating of every architectural write strobe.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Instr carries instruction bits [31:12]
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^bus.Instr[7:4];

  logic [3:0] state;
  logic [3:0] state_n;
  logic [3:0] flags;

  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_n = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_n = S_MEMADR;
          2'b10:   state_n = S_BRANCH;
          default: state_n = S_FETCH;
        endcase
      end
      S_MEMADR:   state_n = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_n = S_MEMWB;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE: state_n = S_FETCH;
      S_EXECR:    state_n = S_ALUWB;
      S_EXECI:    state_n = S_ALUWB;
      S_ALUWB:    state_n = S_FETCH;
      S_BRANCH:   state_n = S_FETCH;
      default:    state_n = S_FETCH;
    endcase
  end

  // During reset the selects follow FETCH so the datapath sees a sane PC path
  logic [3:0] ctl_state;
  assign ctl_state = reset ? S_FETCH : state;

  logic       next_pc;
  logic       ir_write;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       alu_op;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;

  always_comb begin
    next_pc    = 1'b0;
    ir_write   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    case (ctl_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:   alu_src_b = 2'b01;
      S_MEMREAD:  adr_src   = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECR:    alu_op = 1'b1;
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  logic [1:0] alu_control;
  logic [1:0] flag_w;
  logic       cmd_known;
  logic       no_write;

  always_comb begin
    alu_control = 2'b00;
    cmd_known   = 1'b1;
    case (cmd)
      CMD_ADD: alu_control = 2'b00;
      CMD_SUB: alu_control = 2'b01;
      CMD_AND: alu_control = 2'b10;
      CMD_ORR: alu_control = 2'b11;
      CMD_CMP: alu_control = 2'b01;
      default: cmd_known   = 1'b0;
    endcase
    if (!alu_op) begin
      alu_control = 2'b00;
      cmd_known   = 1'b0;
    end
    flag_w[1] = cmd_known & funct[0];
    flag_w[0] = cmd_known & funct[0] &
                ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
  end

  // CMP must also suppress the writeback in ALUWB, where ALUOp is already low
  assign no_write = (op == 2'b00) && (cmd == CMD_CMP);

  logic n_f, z_f, c_f, v_f;
  logic cond_ex;
  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic exec_state;
  assign exec_state = (state == S_EXECR) || (state == S_EXECI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      flags <= 4'b0000;
    end else begin
      state <= state_n;
      if (exec_state && flag_w[1] && cond_ex) flags[3:2] <= bus.ALUFlags[3:2];
      if (exec_state && flag_w[0] && cond_ex) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  logic reg_write_g;
  assign reg_write_g = reg_w & cond_ex & ~no_write;

  // Strobes from ctl_state are already zero in reset except FETCH ones, masked here
  assign bus.IRWrite    = ir_write & ~reset;
  assign bus.RegWrite   = reg_write_g & ~reset;
  assign bus.MemWrite   = mem_w & cond_ex & ~reset;
  assign bus.PCWrite    = ~reset & (next_pc | (branch & cond_ex) |
                                    (reg_write_g & (rd == 4'hF)));
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Per-cycle vector bench for multicycle_controller: table rows plus reset-abort sequence.
module tb_multicycle_controller;
  localparam int W = 21;

  logic clk;
  logic reset;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strb = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc}
  // sel  = {ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
  typedef struct packed {
    logic        rst;
    logic [19:0] instr;
    logic [3:0]  af;
    logic [3:0]  st;
    logic [4:0]  strb;
    logic [7:0]  sel;
  } vec_t;

  vec_t tbl[$];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [7:0] SEL_FD   = 8'b10_01_10_00;
  localparam logic [7:0] SEL_ZERO = 8'b00_00_00_00;
  localparam logic [7:0] SEL_IMM  = 8'b00_00_01_00;
  localparam logic [7:0] SEL_BR   = 8'b10_00_01_00;

  localparam logic [19:0] I_ADD    = 20'hE0821;
  localparam logic [19:0] I_LDR    = 20'hE5921;
  localparam logic [19:0] I_STR    = 20'hE5821;
  localparam logic [19:0] I_SUBS   = 20'hE0511;
  localparam logic [19:0] I_BEQ    = 20'h0A000;
  localparam logic [19:0] I_CMP    = 20'hE1510;
  localparam logic [19:0] I_ADDNES = 20'h10921;
  localparam logic [19:0] I_ADDPC  = 20'hE082F;
  localparam logic [19:0] I_ADDI   = 20'hE2821;
  localparam logic [19:0] I_AND    = 20'hE0021;
  localparam logic [19:0] I_ORR    = 20'hE1821;
  localparam logic [19:0] I_UND    = 20'hEC000;
  localparam logic [19:0] I_NVADD  = 20'hF0821;
  localparam logic [19:0] I_NVB    = 20'hFA000;
  localparam logic [19:0] I_BGE    = 20'hAA000;
  localparam logic [19:0] I_BLT    = 20'hBA000;

  function automatic vec_t mk(input logic rst, input logic [19:0] i, input logic [3:0] af,
                              input logic [3:0] st, input logic [4:0] strb, input logic [7:0] sel);
    vec_t v;
    v.rst = rst; v.instr = i; v.af = af; v.st = st; v.strb = strb; v.sel = sel;
    return v;
  endfunction

  function automatic logic [W-1:0] pack_exp(input vec_t v);
    logic [1:0] op;
    op = v.instr[15:14];
    return {v.st, v.strb, v.sel, op, op == 2'b01, op == 2'b10};
  endfunction

  task automatic r(input logic [19:0] i, input logic [3:0] af, input logic [3:0] st,
                   input logic [4:0] strb, input logic [7:0] sel);
    tbl.push_back(mk(1'b0, i, af, st, strb, sel));
  endtask

  // FETCH and DECODE rows shared by every instruction
  task automatic fd(input logic [19:0] i);
    r(i, 4'h0, 4'd0, 5'b11000, SEL_FD);
    r(i, 4'h0, 4'd1, 5'b00000, SEL_FD);
  endtask

  task automatic run_row(input vec_t v, input int idx);
    logic [W-1:0] got;
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    reset        = v.rst;
    bus.Instr    = v.instr;
    bus.ALUFlags = v.af;
    exp_q.push_back(pack_exp(v));
    @(negedge clk);
    got = {bus.State, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
           bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL ctl_row %0d instr=%h: got st=%0d strb=%b sel=%b imm/reg=%b, expected st=%0d strb=%b sel=%b imm/reg=%b",
               idx, v.instr, got[20:17], got[16:12], got[11:4], got[3:0],
               e[20:17], e[16:12], e[11:4], e[3:0]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.Instr    = '0;
    bus.ALUFlags = '0;
    repeat (2) @(posedge clk);

    tbl.push_back(mk(1'b1, 20'h00000, 4'h0, 4'd0, 5'b00000, SEL_FD));
    // ADD R1,R2,R3
    fd(I_ADD);  r(I_ADD, 4'h0, 4'd6, 5'b00000, SEL_ZERO); r(I_ADD, 4'h0, 4'd8, 5'b00100, SEL_ZERO);
    // LDR R1,[R2,#4]
    fd(I_LDR);  r(I_LDR, 4'h0, 4'd2, 5'b00000, SEL_IMM);
    r(I_LDR, 4'h0, 4'd3, 5'b00001, SEL_ZERO); r(I_LDR, 4'h0, 4'd4, 5'b00100, 8'b01_00_00_00);
    // STR R1,[R2,#4]
    fd(I_STR);  r(I_STR, 4'h0, 4'd2, 5'b00000, SEL_IMM); r(I_STR, 4'h0, 4'd5, 5'b00011, SEL_ZERO);
    // SUBS sets Z; BEQ taken
    fd(I_SUBS); r(I_SUBS, 4'b0100, 4'd6, 5'b00000, 8'b00_00_00_01); r(I_SUBS, 4'h0, 4'd8, 5'b00100, SEL_ZERO);
    fd(I_BEQ);  r(I_BEQ, 4'h0, 4'd9, 5'b10000, SEL_BR);
    // CMP clears flags, no register write; BEQ not taken
    fd(I_CMP);  r(I_CMP, 4'b0000, 4'd6, 5'b00000, 8'b00_00_00_01); r(I_CMP, 4'h0, 4'd8, 5'b00000, SEL_ZERO);
    fd(I_BEQ);  r(I_BEQ, 4'h0, 4'd9, 5'b00000, SEL_BR);
    // ADDNES with Z set: no write, flags keep Z so BEQ is taken
    fd(I_SUBS); r(I_SUBS, 4'b0100, 4'd6, 5'b00000, 8'b00_00_00_01); r(I_SUBS, 4'h0, 4'd8, 5'b00100, SEL_ZERO);
    fd(I_ADDNES); r(I_ADDNES, 4'b1000, 4'd6, 5'b00000, SEL_ZERO); r(I_ADDNES, 4'h0, 4'd8, 5'b00000, SEL_ZERO);
    fd(I_BEQ);  r(I_BEQ, 4'h0, 4'd9, 5'b10000, SEL_BR);
    // ADD to R15 writes the PC
    fd(I_ADDPC); r(I_ADDPC, 4'h0, 4'd6, 5'b00000, SEL_ZERO); r(I_ADDPC, 4'h0, 4'd8, 5'b10100, SEL_ZERO);
    // Immediate ADD, AND, ORR
    fd(I_ADDI); r(I_ADDI, 4'h0, 4'd7, 5'b00000, SEL_IMM); r(I_ADDI, 4'h0, 4'd8, 5'b00100, SEL_ZERO);
    fd(I_AND);  r(I_AND, 4'h0, 4'd6, 5'b00000, 8'b00_00_00_10); r(I_AND, 4'h0, 4'd8, 5'b00100, SEL_ZERO);
    fd(I_ORR);  r(I_ORR, 4'h0, 4'd6, 5'b00000, 8'b00_00_00_11); r(I_ORR, 4'h0, 4'd8, 5'b00100, SEL_ZERO);
    // Undefined Op=11 is a 2-cycle NOP
    fd(I_UND);
    // Cond 1111 never executes
    fd(I_NVADD); r(I_NVADD, 4'h0, 4'd6, 5'b00000, SEL_ZERO); r(I_NVADD, 4'h0, 4'd8, 5'b00000, SEL_ZERO);
    fd(I_NVB);   r(I_NVB, 4'h0, 4'd9, 5'b00000, SEL_BR);
    // Signed conditions with N=V=1
    fd(I_SUBS); r(I_SUBS, 4'b1001, 4'd6, 5'b00000, 8'b00_00_00_01); r(I_SUBS, 4'h0, 4'd8, 5'b00100, SEL_ZERO);
    fd(I_BGE);  r(I_BGE, 4'h0, 4'd9, 5'b10000, SEL_BR);
    fd(I_BLT);  r(I_BLT, 4'h0, 4'd9, 5'b00000, SEL_BR);

    for (int k = 0; k < tbl.size(); k++) run_row(tbl[k], k);

    // Reset during MEMWRITE: no store, flags cleared, next instruction normal
    run_row(mk(1'b0, I_SUBS, 4'h0, 4'd0, 5'b11000, SEL_FD), 1000);
    run_row(mk(1'b0, I_SUBS, 4'h0, 4'd1, 5'b00000, SEL_FD), 1001);
    run_row(mk(1'b0, I_SUBS, 4'b0100, 4'd6, 5'b00000, 8'b00_00_00_01), 1002);
    run_row(mk(1'b0, I_SUBS, 4'h0, 4'd8, 5'b00100, SEL_ZERO), 1003);
    run_row(mk(1'b0, I_STR, 4'h0, 4'd0, 5'b11000, SEL_FD), 1004);
    run_row(mk(1'b0, I_STR, 4'h0, 4'd1, 5'b00000, SEL_FD), 1005);
    run_row(mk(1'b0, I_STR, 4'h0, 4'd2, 5'b00000, SEL_IMM), 1006);
    run_row(mk(1'b1, I_STR, 4'h0, 4'd5, 5'b00000, SEL_FD), 1007);
    run_row(mk(1'b0, I_BEQ, 4'h0, 4'd0, 5'b11000, SEL_FD), 1008);
    run_row(mk(1'b0, I_BEQ, 4'h0, 4'd1, 5'b00000, SEL_FD), 1009);
    run_row(mk(1'b0, I_BEQ, 4'h0, 4'd9, 5'b00000, SEL_BR), 1010);
    run_row(mk(1'b0, I_ADD, 4'h0, 4'd0, 5'b11000, SEL_FD), 1011);
    run_row(mk(1'b0, I_ADD, 4'h0, 4'd1, 5'b00000, SEL_FD), 1012);
    run_row(mk(1'b0, I_ADD, 4'h0, 4'd6, 5'b00000, SEL_ZERO), 1013);
    run_row(mk(1'b0, I_ADD, 4'h0, 4'd8, 5'b00100, SEL_ZERO), 1014);
    run_row(mk(1'b0, I_ADD, 4'h0, 4'd0, 5'b11000, SEL_FD), 1015);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
